// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: four-stage pipelined YCbCr to RGB converter.
// The conversion standard is captured on each VS_in rising edge, so a frame
// never switches coefficient sets part-way through. Syncs ride alongside the
// data and RGB is optionally forced to zero outside the active region.
module ycbcr2rgb #(
    parameter int C_DATA_WIDTH = 10,
    parameter bit C_BLANK_ZERO = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              convert_std,
    input  logic                    VS_in,
    input  logic                    HS_in,
    input  logic                    DE_in,
    input  logic [C_DATA_WIDTH-1:0] Y_in,
    input  logic [C_DATA_WIDTH-1:0] Cb_in,
    input  logic [C_DATA_WIDTH-1:0] Cr_in,
    output logic                    VS_out,
    output logic                    HS_out,
    output logic                    DE_out,
    output logic [C_DATA_WIDTH-1:0] R_out,
    output logic [C_DATA_WIDTH-1:0] G_out,
    output logic [C_DATA_WIDTH-1:0] B_out
);

    localparam int DW = C_DATA_WIDTH;
    localparam int OW = DW + 2;   // offset-removed component width
    localparam int PW = DW + 20;  // product width
    localparam int SW = DW + 22;  // sum width, wide enough that sums never wrap

    localparam logic signed [OW-1:0] Y_OFS  = OW'(16 << (DW - 8));
    localparam logic signed [OW-1:0] C_OFS  = OW'(1 << (DW - 1));
    localparam logic signed [OW-1:0] ZERO_O = '0;
    localparam logic signed [SW-1:0] ROUND  = SW'(1 << 14);

    // Q15 coefficient sets
    localparam logic signed [17:0] SD_KY   =  18'sd32768;
    localparam logic signed [17:0] SD_CRR  =  18'sd44915;
    localparam logic signed [17:0] SD_CBG  = -18'sd11025;
    localparam logic signed [17:0] SD_CRG  = -18'sd22878;
    localparam logic signed [17:0] SD_CBB  =  18'sd56769;
    localparam logic signed [17:0] HD_KY   =  18'sd32768;
    localparam logic signed [17:0] HD_CRR  =  18'sd50451;
    localparam logic signed [17:0] HD_CBG  = -18'sd6002;
    localparam logic signed [17:0] HD_CRG  = -18'sd14997;
    localparam logic signed [17:0] HD_CBB  =  18'sd59459;
    localparam logic signed [17:0] SR_KY   =  18'sd38142;
    localparam logic signed [17:0] SR_CRR  =  18'sd52298;
    localparam logic signed [17:0] SR_CBG  = -18'sd12845;
    localparam logic signed [17:0] SR_CRG  = -18'sd26640;
    localparam logic signed [17:0] SR_CBB  =  18'sd66093;

    // Clamp a Q15 sum to the unsigned output range after dropping 15 fraction bits.
    function automatic logic [DW-1:0] saturate(input logic signed [SW-1:0] s);
        logic [DW-1:0] r;
        if (s[SW-1]) begin
            r = '0;
        end else if (|s[SW-2:DW+15]) begin
            r = '1;
        end else begin
            r = s[DW+14:15];
        end
        return r;
    endfunction

    // ---------------- standard latch ----------------
    logic       vs_prev;
    logic [1:0] std_active;
    logic       vs_rise;
    logic [1:0] std_eff;

    assign vs_rise = VS_in & ~vs_prev;
    // The pixel carrying the VS edge already uses the newly captured standard.
    assign std_eff = vs_rise ? convert_std : std_active;

    // Remember VS_in and capture the requested standard on its rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_prev    <= 1'b1;
            std_active <= 2'b00;
        end else begin
            vs_prev <= VS_in;
            if (vs_rise) begin
                std_active <= convert_std;
            end
        end
    end

    // ---------------- stage 1 ----------------
    logic signed [17:0] c_ky, c_crr, c_cbg, c_crg, c_cbb;
    logic signed [OW-1:0] y_sub, yo_n, cbo_n, cro_n;

    // Pick the coefficient set and remove the black/chroma offsets.
    always_comb begin
        c_ky  = SD_KY;
        c_crr = SD_CRR;
        c_cbg = SD_CBG;
        c_crg = SD_CRG;
        c_cbb = SD_CBB;
        if (std_eff[1]) begin
            c_ky  = SR_KY;
            c_crr = SR_CRR;
            c_cbg = SR_CBG;
            c_crg = SR_CRG;
            c_cbb = SR_CBB;
        end else if (std_eff[0]) begin
            c_ky  = HD_KY;
            c_crr = HD_CRR;
            c_cbg = HD_CBG;
            c_crg = HD_CRG;
            c_cbb = HD_CBB;
        end
        y_sub = std_eff[1] ? Y_OFS : ZERO_O;
        yo_n  = $signed({2'b00, Y_in})  - y_sub;
        cbo_n = $signed({2'b00, Cb_in}) - C_OFS;
        cro_n = $signed({2'b00, Cr_in}) - C_OFS;
    end

    logic signed [OW-1:0] s1_yo, s1_cbo, s1_cro;
    logic signed [17:0]   s1_ky, s1_crr, s1_cbg, s1_crg, s1_cbb;
    logic                 s1_vs, s1_hs, s1_de;

    // Stage 1 register: offset-free components plus their coefficient set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_yo  <= '0;
            s1_cbo <= '0;
            s1_cro <= '0;
            s1_ky  <= '0;
            s1_crr <= '0;
            s1_cbg <= '0;
            s1_crg <= '0;
            s1_cbb <= '0;
            s1_vs  <= 1'b1;
            s1_hs  <= 1'b1;
            s1_de  <= 1'b0;
        end else begin
            s1_yo  <= yo_n;
            s1_cbo <= cbo_n;
            s1_cro <= cro_n;
            s1_ky  <= c_ky;
            s1_crr <= c_crr;
            s1_cbg <= c_cbg;
            s1_crg <= c_crg;
            s1_cbb <= c_cbb;
            s1_vs  <= VS_in;
            s1_hs  <= HS_in;
            s1_de  <= DE_in;
        end
    end

    // ---------------- stage 2 ----------------
    logic signed [PW-1:0] p_y, p_crr, p_cbg, p_crg, p_cbb;
    logic                 s2_vs, s2_hs, s2_de;

    // Stage 2 register: the five partial products, operands sign-extended first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_y   <= '0;
            p_crr <= '0;
            p_cbg <= '0;
            p_crg <= '0;
            p_cbb <= '0;
            s2_vs <= 1'b1;
            s2_hs <= 1'b1;
            s2_de <= 1'b0;
        end else begin
            p_y   <= PW'(s1_yo)  * PW'(s1_ky);
            p_crr <= PW'(s1_cro) * PW'(s1_crr);
            p_cbg <= PW'(s1_cbo) * PW'(s1_cbg);
            p_crg <= PW'(s1_cro) * PW'(s1_crg);
            p_cbb <= PW'(s1_cbo) * PW'(s1_cbb);
            s2_vs <= s1_vs;
            s2_hs <= s1_hs;
            s2_de <= s1_de;
        end
    end

    // ---------------- stage 3 ----------------
    logic signed [SW-1:0] s3_r, s3_g, s3_b;
    logic                 s3_vs, s3_hs, s3_de;

    // Stage 3 register: channel sums with the half-LSB rounding term.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_r  <= '0;
            s3_g  <= '0;
            s3_b  <= '0;
            s3_vs <= 1'b1;
            s3_hs <= 1'b1;
            s3_de <= 1'b0;
        end else begin
            s3_r  <= SW'(p_y) + SW'(p_crr) + ROUND;
            s3_g  <= SW'(p_y) + SW'(p_cbg) + SW'(p_crg) + ROUND;
            s3_b  <= SW'(p_y) + SW'(p_cbb) + ROUND;
            s3_vs <= s2_vs;
            s3_hs <= s2_hs;
            s3_de <= s2_de;
        end
    end

    // ---------------- stage 4 ----------------
    logic blank;
    assign blank = C_BLANK_ZERO && !s3_de;

    // Output register: scale back to integer, clamp, and blank outside DE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            R_out  <= '0;
            G_out  <= '0;
            B_out  <= '0;
            VS_out <= 1'b1;
            HS_out <= 1'b1;
            DE_out <= 1'b0;
        end else begin
            R_out  <= blank ? '0 : saturate(s3_r);
            G_out  <= blank ? '0 : saturate(s3_g);
            B_out  <= blank ? '0 : saturate(s3_b);
            VS_out <= s3_vs;
            HS_out <= s3_hs;
            DE_out <= s3_de;
        end
    end

endmodule

// File: tb/tb_ycbcr2rgb.sv
// tb_ycbcr2rgb: directed and random stimulus for ycbcr2rgb, checked against
// a behavioural conversion model through an expected-output queue.
module tb_ycbcr2rgb;

    localparam int DW = 10;
    localparam int W  = 3 + 3 * DW;   // {vs, hs, de, r, g, b}
    localparam logic [W-1:0] RESET_VEC = {1'b1, 1'b1, 1'b0, {(3*DW){1'b0}}};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    convert_std = 2'b00;
    logic          vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    logic [DW-1:0] y_in = '0, cb_in = '0, cr_in = '0;
    logic          vs_out, hs_out, de_out;
    logic [DW-1:0] r_out, g_out, b_out;

    ycbcr2rgb #(.C_DATA_WIDTH(DW), .C_BLANK_ZERO(1'b1)) dut (
        .clk(clk),
        .reset(reset),
        .convert_std(convert_std),
        .VS_in(vs_in),
        .HS_in(hs_in),
        .DE_in(de_in),
        .Y_in(y_in),
        .Cb_in(cb_in),
        .Cr_in(cr_in),
        .VS_out(vs_out),
        .HS_out(hs_out),
        .DE_out(de_out),
        .R_out(r_out),
        .G_out(g_out),
        .B_out(b_out)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_pass = 0;
    int           n_total = 0;
    int           n_fail = 0;
    logic [1:0]   m_std = 2'b00;
    logic         m_prev = 1'b1;

    function automatic logic [DW-1:0] clamp(input int v);
        int mx;
        mx = (1 << DW) - 1;
        if (v < 0) return '0;
        if (v > mx) return '1;
        return v[DW-1:0];
    endfunction

    // Behavioural conversion: offsets, Q15 coefficients, round, clamp, blank.
    function automatic logic [W-1:0] model(input logic vs, hs, de,
                                           input logic [DW-1:0] y, cb, cr,
                                           input logic [1:0] std);
        int ky, crr, cbg, crg, cbb;
        int yo, cbo, cro, rs, gs, bs;
        logic [DW-1:0] r, g, b;
        if (std[1]) begin
            ky = 38142; crr = 52298; cbg = -12845; crg = -26640; cbb = 66093;
        end else if (std[0]) begin
            ky = 32768; crr = 50451; cbg = -6002;  crg = -14997; cbb = 59459;
        end else begin
            ky = 32768; crr = 44915; cbg = -11025; crg = -22878; cbb = 56769;
        end
        yo  = int'(y) - (std[1] ? (16 << (DW - 8)) : 0);
        cbo = int'(cb) - (1 << (DW - 1));
        cro = int'(cr) - (1 << (DW - 1));
        rs  = (yo * ky + cro * crr + 16384) >>> 15;
        gs  = (yo * ky + cbo * cbg + cro * crg + 16384) >>> 15;
        bs  = (yo * ky + cbo * cbb + 16384) >>> 15;
        r = clamp(rs);
        g = clamp(gs);
        b = clamp(bs);
        if (!de) begin
            r = '0; g = '0; b = '0;
        end
        return {vs, hs, de, r, g, b};
    endfunction

    function automatic logic [W-1:0] observed();
        return {vs_out, hs_out, de_out, r_out, g_out, b_out};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got vs/hs/de=%b%b%b rgb=%0d,%0d,%0d expected vs/hs/de=%b%b%b rgb=%0d,%0d,%0d",
                   tag, obs[W-1], obs[W-2], obs[W-3], obs[3*DW-1:2*DW], obs[2*DW-1:DW], obs[DW-1:0],
                   exp[W-1], exp[W-2], exp[W-3], exp[3*DW-1:2*DW], exp[2*DW-1:DW], exp[DW-1:0]);
        end
    endtask

    // After reset the three inner stages hold cleared values that will drain first.
    task automatic prefill_after_reset();
        exp_q.delete();
        tag_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(RESET_VEC);
            tag_q.push_back("post_reset_drain");
        end
        m_std  = 2'b00;
        m_prev = 1'b1;
    endtask

    // ---------------- driver ----------------
    // Drive one pixel, record its expected output, clock once, compare the oldest entry.
    task automatic step(input string tag, input logic vs, hs, de,
                        input logic [DW-1:0] y, cb, cr, input logic [1:0] cs);
        logic [W-1:0] e;
        string t;
        convert_std = cs;
        vs_in = vs; hs_in = hs; de_in = de;
        y_in = y; cb_in = cb; cr_in = cr;
        if (vs && !m_prev) m_std = cs;
        m_prev = vs;
        exp_q.push_back(model(vs, hs, de, y, cb, cr, m_std));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 4) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, observed(), e);
        end
    endtask

    task automatic idle(input int n, input logic vs, input logic [1:0] cs);
        for (int i = 0; i < n; i++) step("idle", vs, 1'b1, 1'b0, '0, '0, '0, cs);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", observed(), RESET_VEC);
        #2 reset = 1'b0;
        prefill_after_reset();

        // Latch SD through a VS rise, then the SD test pixels.
        idle(2, 1'b0, 2'b00);
        idle(2, 1'b1, 2'b00);
        idle(1, 1'b0, 2'b00);
        step("sd_mid",      1'b0, 1'b0, 1'b1, 10'd512,  10'd512, 10'd512,  2'b00);
        step("sd_sat_hi",   1'b0, 1'b0, 1'b1, 10'd1023, 10'd512, 10'd1023, 2'b00);
        step("sd_sat_lo",   1'b0, 1'b0, 1'b1, 10'd0,    10'd512, 10'd0,    2'b00);
        step("sd_cr_max",   1'b0, 1'b0, 1'b1, 10'd512,  10'd512, 10'd1023, 2'b00);
        // Request HD mid-frame: must not take effect yet.
        step("std_pending", 1'b0, 1'b0, 1'b1, 10'd512,  10'd512, 10'd1023, 2'b01);
        step("std_pending", 1'b0, 1'b1, 1'b1, 10'd512,  10'd512, 10'd1023, 2'b01);
        // VS edge pixel already uses HD.
        step("hd_edge",     1'b1, 1'b0, 1'b1, 10'd512,  10'd512, 10'd1023, 2'b01);
        step("hd_next",     1'b1, 1'b0, 1'b1, 10'd300,  10'd100, 10'd900,  2'b01);
        step("hd_low",      1'b0, 1'b0, 1'b1, 10'd700,  10'd900, 10'd100,  2'b00);
        // sRGB request: ignored until the next VS rise.
        step("srgb_pend",   1'b0, 1'b0, 1'b1, 10'd64,   10'd512, 10'd512,  2'b10);
        step("srgb_black",  1'b1, 1'b0, 1'b1, 10'd64,   10'd512, 10'd512,  2'b10);
        step("srgb_white",  1'b1, 1'b0, 1'b1, 10'd940,  10'd512, 10'd512,  2'b10);
        step("srgb_bit0",   1'b0, 1'b0, 1'b1, 10'd500,  10'd700, 10'd300,  2'b11);
        // Blanking and sync pass-through.
        step("blank",       1'b0, 1'b1, 1'b0, 10'd940,  10'd512, 10'd512,  2'b10);
        step("blank_vs",    1'b1, 1'b0, 1'b0, 10'd940,  10'd800, 10'd900,  2'b10);
        step("sync_pat",    1'b0, 1'b1, 1'b1, 10'd940,  10'd512, 10'd512,  2'b10);
        step("sync_pat",    1'b1, 1'b1, 1'b0, 10'd20,   10'd1,   10'd1000, 2'b10);

        // Random pixels, syncs and standard requests.
        for (int i = 0; i < 80; i++) begin
            step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)),
                 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 2'($urandom_range(0, 3)));
        end

        // Asynchronous reset with live pixels in flight.
        step("pre_reset", 1'b0, 1'b0, 1'b1, 10'd900, 10'd200, 10'd800, 2'b00);
        step("pre_reset", 1'b0, 1'b0, 1'b1, 10'd800, 10'd300, 10'd700, 2'b00);
        #2 reset = 1'b1;
        #1;
        check("async_reset", observed(), RESET_VEC);
        @(posedge clk);
        #1;
        check("reset_hold", observed(), RESET_VEC);
        #2 reset = 1'b0;
        prefill_after_reset();
        step("after_reset", 1'b0, 1'b0, 1'b1, 10'd512, 10'd512, 10'd512, 2'b11);
        step("after_reset", 1'b0, 1'b0, 1'b1, 10'd0,   10'd512, 10'd0,   2'b11);
        step("after_reset", 1'b0, 1'b1, 1'b1, 10'd700, 10'd600, 10'd650, 2'b01);
        idle(5, 1'b0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
